// File: rtl/md_sched.sv
// rtl/md_sched.sv - HI/LO multiply/divide scheduler with a down-counter busy window
// Optional MD_DIVZERO_KEEP_EN: divide by zero leaves HI/LO unchanged instead of hi=rs, lo=all-ones.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        flush,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hl_rdata
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;

    logic        is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign is_signed = (req_op == 4'd1) || (req_op == 4'd3);
    assign a_ext     = is_signed ? {{32{rs[31]}}, rs} : {32'b0, rs};
    assign b_ext     = is_signed ? {{32{rt[31]}}, rt} : {32'b0, rt};
    assign prod      = a_ext * b_ext;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
    assign a_mag  = (is_signed && rs[31]) ? -rs : rs;
    assign b_mag  = (is_signed && rt[31]) ? -rt : rt;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (is_signed && (rs[31] ^ rt[31])) ? -q_mag : q_mag;
    assign rem    = (is_signed && rs[31]) ? -r_mag : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    case (req_op)
                        4'd1, 4'd2: begin
                            phi_d   = prod[63:32];
                            plo_d   = prod[31:0];
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        4'd3, 4'd4: begin
                            if (rt == 32'd0) begin
`ifdef MD_DIVZERO_KEEP_EN
                                phi_d = hi_q;
                                plo_d = lo_q;
`else
                                phi_d = rs;
                                plo_d = 32'hFFFF_FFFF;
`endif
                            end else begin
                                phi_d = rem;
                                plo_d = quot;
                            end
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        4'd5:    hi_d = rs;
                        4'd6:    lo_d = rs;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    phi_d   = '0;
                    plo_d   = '0;
                end else if (cnt_q == CW'(1)) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign stall    = d_is_md && (busy || (req_valid && (req_op >= 4'd1) && (req_op <= 4'd4)));
    assign hl_rdata = (req_op == 4'd7) ? hi_q : (req_op == 4'd8) ? lo_q : 32'd0;
endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - randomized scoreboard bench for md_sched against an arithmetic HI/LO model
module tb_md_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] rs = 32'd0;
    logic [31:0] rt = 32'd0;
    logic        flush = 1'b0;
    logic        d_is_md = 1'b0;
    logic        busy, stall;
    logic [31:0] hl_rdata;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .rs(rs), .rt(rt), .flush(flush), .d_is_md(d_is_md),
        .busy(busy), .stall(stall), .hl_rdata(hl_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        stall;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] hi_m = 32'd0, lo_m = 32'd0, phi_m = 32'd0, plo_m = 32'd0;
    int          left_m = 0;

    localparam logic [32:0] NK = 33'd0;

    function automatic logic [32:0] K(input logic [31:0] x);
        return {1'b1, x};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", {31'd0, busy}, {31'd0, e.busy});
            chk("stall", {31'd0, stall}, {31'd0, e.stall});
            chk("hl_rdata", hl_rdata, e.rd);
        end
    end

    always @(negedge clk) begin
        if (reset && busy && req_valid && !flush)
            $error("request issued while unit busy");
    end

    // One pipeline cycle: drive inputs, queue the expected outputs, advance the model past the edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, input logic dm, input logic [32:0] k);
        exp_t    e;
        longint  sa, sb, q, r;
        longint unsigned ua, ub, uq, ur, pu;
        @(posedge clk);
        #1;
        req_valid = v; req_op = op; rs = a; rt = b; flush = fl; d_is_md = dm;
        e.busy  = (left_m > 0);
        e.stall = dm && ((left_m > 0) || (v && op >= 4'd1 && op <= 4'd4));
        e.rd    = (op == 4'd7) ? hi_m : (op == 4'd8) ? lo_m : 32'd0;
        if (k[32]) e.rd = k[31:0];
        exp_q.push_back(e);

        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (left_m > 0) begin
            if (fl) left_m = 0;
            else begin
                left_m--;
                if (left_m == 0) begin
                    hi_m = phi_m;
                    lo_m = plo_m;
                end
            end
        end else if (v && !fl) begin
            case (op)
                4'd1: begin q = sa * sb; {phi_m, plo_m} = q[63:0]; left_m = 5; end
                4'd2: begin pu = ua * ub; {phi_m, plo_m} = pu[63:0]; left_m = 5; end
                4'd3, 4'd4: begin
                    left_m = 10;
                    if (b == 32'd0) begin
`ifdef MD_DIVZERO_KEEP_EN
                        phi_m = hi_m; plo_m = lo_m;
`else
                        phi_m = a; plo_m = 32'hFFFF_FFFF;
`endif
                    end else if (op == 4'd3) begin
                        q = sa / sb; r = sa % sb;
                        plo_m = q[31:0]; phi_m = r[31:0];
                    end else begin
                        uq = ua / ub; ur = ua % ub;
                        plo_m = uq[31:0]; phi_m = ur[31:0];
                    end
                end
                4'd5: hi_m = a;
                4'd6: lo_m = a;
                default: ;
            endcase
        end
    endtask

    task automatic idle(input int n, input logic dm);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, dm, NK);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        v, fl, dm;
        logic [3:0]  op;
        logic [31:0] a, b;

        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        d_is_md = 1'b1;
        #1 chk("reset_stall", {31'd0, stall}, 32'd0);
        req_op = 4'd7;
        #1 chk("reset_hi", hl_rdata, 32'd0);
        req_op = 4'd8;
        #0.5 chk("reset_lo", hl_rdata, 32'd0);
        reset = 1'b1;

        step(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, NK);
        idle(5, 1'b1);
        step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b1, K(32'hFFFF_FFFA));
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'hFFFF_FFFF));

        step(1'b1, 4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, NK);
        idle(5, 1'b0);
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'h0000_0002));
        step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, K(32'hFFFF_FFFA));

        step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, NK);
        idle(10, 1'b0);
        step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, K(32'hFFFF_FFFD));
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'hFFFF_FFFF));

        step(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, NK);
        idle(10, 1'b0);
        step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, K(32'h8000_0000));
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'h0000_0000));

        step(1'b1, 4'd5, 32'h11, 32'd0, 1'b0, 1'b0, NK);
        step(1'b1, 4'd6, 32'h22, 32'd0, 1'b0, 1'b0, NK);
        step(1'b1, 4'd4, 32'd10, 32'd0, 1'b0, 1'b0, NK);
        idle(10, 1'b0);
`ifdef MD_DIVZERO_KEEP_EN
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'h11));
        step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, K(32'h22));
`else
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'd10));
        step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, K(32'hFFFF_FFFF));
`endif

        step(1'b1, 4'd5, 32'hAAAA, 32'd0, 1'b0, 1'b0, NK);
        step(1'b1, 4'd6, 32'h5555, 32'd0, 1'b0, 1'b0, NK);
        step(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0, NK);
        idle(3, 1'b0);
        step(1'b1, 4'd1, 32'd5, 32'd6, 1'b1, 1'b0, NK);
        idle(2, 1'b1);
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'hAAAA));
        step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, K(32'h5555));
        step(1'b1, 4'd5, 32'hDEAD, 32'd0, 1'b1, 1'b0, NK);
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'hAAAA));

        step(1'b1, 4'd3, 32'd50, 32'd3, 1'b0, 1'b0, NK);
        idle(3, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 chk("async_rst_busy", {31'd0, busy}, 32'd0);
        req_op = 4'd7;
        #1 chk("async_rst_hi", hl_rdata, 32'd0);
        req_op = 4'd8;
        #1 chk("async_rst_lo", hl_rdata, 32'd0);
        req_op = 4'd0;
        hi_m = 32'd0; lo_m = 32'd0; left_m = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, 4'd5, 32'h1234, 32'd0, 1'b0, 1'b0, NK);
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, K(32'h0000_1234));

        for (int i = 0; i < 600; i++) begin
            fl = ($urandom_range(0, 19) == 0);
            dm = $urandom_range(0, 1);
            op = 4'($urandom_range(0, 15));
            a  = rnd_val();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_val();
            if (left_m > 0) v = fl && $urandom_range(0, 1);
            else            v = ($urandom_range(0, 9) < 7);
            step(v, op, a, b, fl, dm, NK);
        end

        idle(1, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
